// File: rtl/seq_subtractor32.sv
// Digit-serial 32-bit subtractor: A - B - Bin, with borrow-out and signed overflow.
// Processes DIGIT_W bits per BUSY cycle, LSB digit first, using a ready/valid handshake on both sides.
module seq_subtractor32 #(
   parameter int DIGIT_W = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A_in,
   input  logic [31:0] B_in,
   input  logic        Bin_in,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] DIFF_out,
   output logic        Bout_out,
   output logic        V_out,
   output logic        out_valid,
   input  logic        out_ready
);

   localparam int N     = 32 / DIGIT_W;
   localparam int CNT_W = $clog2(N) + 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state, state_nxt;
   logic [31:0]        a_q, b_q, diff_acc, diff_nxt;
   logic               borrow_q, borrow_nxt;
   logic [CNT_W-1:0]   cnt;
   logic               last_digit;
   logic [DIGIT_W:0]   digit_res;
   int                 idx;

   // One digit of A - B - borrow; the extra MSB is the digit's borrow-out.
   function automatic logic [DIGIT_W:0] sub_digit(input logic [DIGIT_W-1:0] a,
                                                  input logic [DIGIT_W-1:0] b,
                                                  input logic               bin);
      return {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, bin};
   endfunction

   assign in_ready   = (state == IDLE);
   assign out_valid  = (state == DONE);
   assign last_digit = (cnt == CNT_W'(N - 1));

   always_comb begin
      idx        = int'(cnt) * DIGIT_W;
      digit_res  = sub_digit(a_q[idx +: DIGIT_W], b_q[idx +: DIGIT_W], borrow_q);
      diff_nxt   = diff_acc;
      diff_nxt[idx +: DIGIT_W] = digit_res[DIGIT_W-1:0];
      borrow_nxt = digit_res[DIGIT_W];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)   state_nxt = BUSY;
         BUSY:    if (last_digit) state_nxt = DONE;
         DONE:    if (out_ready)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         a_q      <= '0;
         b_q      <= '0;
         borrow_q <= 1'b0;
         cnt      <= '0;
         diff_acc <= '0;
         DIFF_out <= '0;
         Bout_out <= 1'b0;
         V_out    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= A_in;
                  b_q      <= B_in;
                  borrow_q <= Bin_in;
                  cnt      <= '0;
                  diff_acc <= '0;
               end
            end
            BUSY: begin
               diff_acc <= diff_nxt;
               borrow_q <= borrow_nxt;
               // Counter stops at the last digit so it never wraps within an operation.
               if (last_digit) begin
                  DIFF_out <= diff_nxt;
                  Bout_out <= borrow_nxt;
                  V_out    <= (a_q[31] ^ b_q[31]) & (a_q[31] ^ diff_nxt[31]);
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_subtractor32.sv
// Directed and random checks of seq_subtractor32 for DIGIT_W = 1, 4 and 32.
module tb_seq_subtractor32;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  in_valid, in_ready, bin_in, bout_out, v_out, out_valid, out_ready;
   logic [31:0] a_in [3];
   logic [31:0] b_in [3];
   logic [31:0] diff_out [3];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   seq_subtractor32 #(.DIGIT_W(1)) u_dw1 (
      .clk(clk), .reset(reset), .A_in(a_in[0]), .B_in(b_in[0]), .Bin_in(bin_in[0]),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .DIFF_out(diff_out[0]),
      .Bout_out(bout_out[0]), .V_out(v_out[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]));

   seq_subtractor32 #(.DIGIT_W(4)) u_dw4 (
      .clk(clk), .reset(reset), .A_in(a_in[1]), .B_in(b_in[1]), .Bin_in(bin_in[1]),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .DIFF_out(diff_out[1]),
      .Bout_out(bout_out[1]), .V_out(v_out[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]));

   seq_subtractor32 #(.DIGIT_W(32)) u_dw32 (
      .clk(clk), .reset(reset), .A_in(a_in[2]), .B_in(b_in[2]), .Bin_in(bin_in[2]),
      .in_valid(in_valid[2]), .in_ready(in_ready[2]), .DIFF_out(diff_out[2]),
      .Bout_out(bout_out[2]), .V_out(v_out[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]));

   function automatic int ndig(input int k);
      case (k)
         0:       return 32;
         1:       return 8;
         default: return 1;
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input int k, input logic [31:0] a, input logic [31:0] b,
                           input logic bin, input string tag);
      int t = 0;
      while (!in_ready[k] && t < 100) begin
         tick();
         t++;
      end
      if (t >= 100) check({tag, "_ready_timeout"}, 64'(in_ready[k]), 64'd1);
      in_valid[k] = 1'b1;
      a_in[k]     = a;
      b_in[k]     = b;
      bin_in[k]   = bin;
      tick();
      in_valid[k] = 1'b0;
   endtask

   task automatic wait_result(input int k, input logic [31:0] exp_diff, input logic exp_b,
                              input logic exp_v, input string tag);
      int cyc = 0;
      while (!out_valid[k] && cyc < 100) begin
         tick();
         cyc++;
      end
      check({tag, "_latency"}, 64'(cyc), 64'(ndig(k)));
      check({tag, "_diff"}, 64'(diff_out[k]), 64'(exp_diff));
      check({tag, "_bout_v"}, 64'({bout_out[k], v_out[k]}), 64'({exp_b, exp_v}));
   endtask

   task automatic release_result(input int k, input string tag);
      out_ready[k] = 1'b1;
      tick();
      out_ready[k] = 1'b0;
      check({tag, "_ovalid_fall"}, 64'(out_valid[k]), 64'd0);
      check({tag, "_iready_back"}, 64'(in_ready[k]), 64'd1);
   endtask

   task automatic directed(input logic [31:0] a, input logic [31:0] b, input logic bin,
                           input logic [31:0] d, input logic bo, input logic v, input string tag);
      start_op(1, a, b, bin, tag);
      wait_result(1, d, bo, v, tag);
      release_result(1, tag);
   endtask

   initial begin
      logic        seen;
      logic [32:0] ref33;
      logic [31:0] ra, rb;
      logic        rbin, rv;

      reset     = 1'b0;
      in_valid  = '0;
      out_ready = '0;
      bin_in    = '0;
      for (int k = 0; k < 3; k++) begin
         a_in[k] = '0;
         b_in[k] = '0;
      end

      // Reset state, with an operand offered that must be ignored
      tick();
      in_valid[1] = 1'b1;
      a_in[1]     = 32'h1234;
      tick();
      tick();
      check("rst_in_ready", 64'(in_ready[1]), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_diff", 64'(diff_out[1]), 64'd0);
      check("rst_bout_v", 64'({bout_out[1], v_out[1]}), 64'd0);
      in_valid[1] = 1'b0;
      reset = 1'b1;
      tick();
      check("post_rst_out_valid", 64'(out_valid[1]), 64'd0);

      directed(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, "simple");
      directed(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, "underflow");
      directed(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, "neg_ovf");
      directed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, "all_ones_bin");
      directed(32'h1234_5678, 32'h1111_1111, 1'b1, 32'h0123_4566, 1'b0, 1'b0, "chain");
      directed(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, "pos_ovf");

      // Backpressure: result held while new operands are offered
      start_op(1, 32'd10, 32'd3, 1'b0, "bp");
      wait_result(1, 32'd7, 1'b0, 1'b0, "bp");
      in_valid[1] = 1'b1;
      a_in[1]     = 32'h100;
      b_in[1]     = 32'h1;
      bin_in[1]   = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_hold_diff", 64'(diff_out[1]), 64'd7);
         check("bp_hold_in_ready", 64'(in_ready[1]), 64'd0);
         check("bp_hold_out_valid", 64'(out_valid[1]), 64'd1);
      end
      out_ready[1] = 1'b1;
      tick();
      out_ready[1] = 1'b0;
      check("bp_release_out_valid", 64'(out_valid[1]), 64'd0);
      check("bp_release_in_ready", 64'(in_ready[1]), 64'd1);
      check("bp_retain_diff", 64'(diff_out[1]), 64'd7);
      tick();
      in_valid[1] = 1'b0;
      wait_result(1, 32'h0000_00FF, 1'b0, 1'b0, "bp_next");
      release_result(1, "bp_next");

      // Reset asserted during the third BUSY cycle aborts the operation
      start_op(1, 32'h1234_5678, 32'h1, 1'b0, "abort");
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("abort_out_valid", 64'(out_valid[1]), 64'd0);
      check("abort_diff", 64'(diff_out[1]), 64'd0);
      check("abort_in_ready", 64'(in_ready[1]), 64'd1);
      reset = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         seen = seen | out_valid[1];
      end
      check("abort_no_pulse", 64'(seen), 64'd0);

      // Random operands on every digit width
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 1000; i++) begin
            ra    = $urandom;
            rb    = $urandom;
            rbin  = 1'($urandom_range(1, 0));
            ref33 = {1'b0, ra} - {1'b0, rb} - {32'd0, rbin};
            rv    = (ra[31] ^ rb[31]) & (ra[31] ^ ref33[31]);
            start_op(k, ra, rb, rbin, "rand");
            wait_result(k, ref33[31:0], ref33[32], rv, "rand");
            release_result(k, "rand");
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
